// File: rtl/ps2_teclado_intr_pkg.sv
// ps2_teclado_pkg: shared scan-code constants, frame length and frame FSM encoding
package ps2_teclado_pkg;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam int FRAME_LEN = 11;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
endpackage

// File: rtl/ps2_teclado_intr_if.sv
// ps2_teclado_intr_if: processor port/interrupt bus between the CPU and the keyboard block
interface ps2_teclado_intr_if;
  logic [7:0] port_id;
  logic read_strobe;
  logic interrupt_ack;
  logic [7:0] in_port;
  logic interrupt;
  modport master(output port_id, read_strobe, interrupt_ack, input in_port, interrupt);
  modport slave(input port_id, read_strobe, interrupt_ack, output in_port, interrupt);
endinterface

// File: rtl/ps2_teclado_intr_line_filter.sv
// ps2_line_filter: synchronizes the PS/2 lines, debounces the clock and emits a tick on its falling edge
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_tick,
  output logic data
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_s, dat_s;
  logic filt, flip;
  logic [CW-1:0] cnt;
  assign flip = (clk_s[1] != filt) && cnt == CW'(FILTER_LEN - 1);
  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample; data is delayed to align with the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt <= 1'b1;
      cnt <= '0;
      fall_tick <= 1'b0;
      data <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      cnt <= (clk_s[1] == filt || flip) ? '0 : cnt + 1'b1;
      filt <= flip ? clk_s[1] : filt;
      fall_tick <= flip && filt;
      data <= dat_s[1];
    end
  end
endmodule

// File: rtl/ps2_teclado_intr.sv
// ps2_teclado_intr: PS/2 keyboard receiver presenting make codes on a CPU port with interrupt/ack
module ps2_teclado_intr
  import ps2_teclado_pkg::*;
#(
  parameter logic [7:0] PORT_ID = 8'h03,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_teclado_intr_if.slave bus,
  output logic overrun,
  output logic frame_error
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [9:0] sr;
  logic [3:0] bit_cnt;
  logic [WW-1:0] wd;
  logic [7:0] code_reg;
  logic interrupt, break_flag, fall_tick, data;
  logic timeout, valid, accept, unused_ok;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fall_tick(fall_tick),
    .data(data)
  );
  assign unused_ok = bus.read_strobe;
  assign bus.interrupt = interrupt;
  assign bus.in_port = bus.port_id == PORT_ID ? code_reg : 8'h00;
  // Frame sequencing and classification of the received byte
  always_comb begin
    timeout = state == SHIFT && !fall_tick && wd == WW'(TIMEOUT);
    valid = sr[9] && ^sr[8:0];
    accept = state == CHECK && valid && sr[7:0] != BREAK_CODE && sr[7:0] != EXT_CODE && !break_flag;
    state_n = state == IDLE ? (fall_tick && !data ? SHIFT : IDLE) :
              state == SHIFT ? (timeout ? IDLE : (fall_tick && bit_cnt == 4'(FRAME_LEN - 2) ? CHECK : SHIFT)) :
              IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Shift/watchdog datapath plus code rules; a make code in the ack cycle keeps interrupt high
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      bit_cnt <= '0;
      wd <= '0;
      code_reg <= '0;
      interrupt <= 1'b0;
      overrun <= 1'b0;
      frame_error <= 1'b0;
      break_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
        wd <= '0;
      end else if (state == SHIFT && fall_tick) begin
        sr <= {data, sr[9:1]};
        bit_cnt <= bit_cnt + 1'b1;
        wd <= '0;
      end else if (state == SHIFT) wd <= wd + 1'b1;
      frame_error <= timeout || (state == CHECK && !valid);
      if (state == CHECK && valid)
        break_flag <= sr[7:0] == BREAK_CODE ? 1'b1 : (sr[7:0] == EXT_CODE ? break_flag : 1'b0);
      if (accept) code_reg <= sr[7:0];
      interrupt <= accept || (interrupt && !bus.interrupt_ack);
      overrun <= overrun || (accept && interrupt && !bus.interrupt_ack);
    end
  end
endmodule

// File: tb/tb_ps2_teclado_intr.sv
// tb_ps2_teclado_intr: random and directed PS/2 frames checked against a rule-level keyboard model
module tb_ps2_teclado_intr;
  import ps2_teclado_pkg::*;
  localparam int HALF = 20;
  localparam int TO = 600;
  logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
  logic overrun, frame_error;
  ps2_teclado_intr_if bus();
  ps2_teclado_intr #(.PORT_ID(8'h03), .FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .bus(bus.slave),
    .overrun(overrun),
    .frame_error(frame_error)
  );
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0] m_code = 0;
  bit m_int = 0, m_ovr = 0, m_brk = 0, settled = 0, fe_prev = 0;
  int m_ferr = 0, ferr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model whenever no frame is completing
  always @(posedge clk) begin
    #1;
    if (frame_error) begin
      chk("frame_error_width", fe_prev, 0);
      ferr_cnt++;
    end
    fe_prev = frame_error;
    if (settled && !reset) begin
      chk("interrupt", bus.interrupt, m_int);
      chk("overrun", overrun, m_ovr);
      chk("in_port", bus.in_port, bus.port_id == 8'h03 ? m_code : 8'h00);
      chk("frame_error_count", ferr_cnt, m_ferr);
      chk("break_flag", dut.break_flag, m_brk);
    end
  end

  task automatic half();
    repeat (HALF) begin
      @(negedge clk);
      bus.port_id = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
      bus.read_strobe = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    ps2_data = b;
    half();
    ps2_clk = 0;
    half();
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad, input bit ack_chk, input bit lat_chk);
    logic [10:0] f;
    bit found, acc, pi;
    int t_tick, t_rise;
    f = {1'b1, ~^code ^ bad, code, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(negedge clk);
    ps2_data = 1;
    half();
    settled = 0;
    ps2_clk = 0;
    found = 0;
    t_tick = -1;
    t_rise = -1;
    pi = bus.interrupt;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      bus.interrupt_ack = ack_chk && dut.state == CHECK;
      if (bus.interrupt_ack) found = 1;
      if (dut.u_filt.fall_tick && t_tick < 0) t_tick = i;
      if (bus.interrupt && !pi && t_rise < 0) t_rise = i;
      pi = bus.interrupt;
    end
    bus.interrupt_ack = 0;
    if (lat_chk) chk("stop_to_interrupt_latency", t_rise - t_tick, 2);
    if (ack_chk) chk("ack_at_check_seen", found, 1);
    ps2_clk = 1;
    acc = 0;
    if (bad) m_ferr++;
    else if (code == BREAK_CODE) m_brk = 1;
    else if (code == EXT_CODE) m_brk = m_brk;
    else if (m_brk) m_brk = 0;
    else begin
      if (m_int && !ack_chk) m_ovr = 1;
      m_int = 1;
      m_code = code;
      acc = 1;
    end
    if (ack_chk && !acc) m_int = 0;
    settled = 1;
    half();
  endtask

  task automatic ack();
    @(negedge clk);
    bus.interrupt_ack = 1;
    m_int = 0;
    @(negedge clk);
    bus.interrupt_ack = 0;
  endtask

  task automatic do_reset();
    settled = 0;
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    m_code = 0;
    m_int = 0;
    m_ovr = 0;
    m_brk = 0;
    half();
    settled = 1;
  endtask

  task automatic peek(input string name, input logic [7:0] pid, input logic [7:0] exp_port, input bit exp_int);
    @(negedge clk);
    bus.port_id = pid;
    #1;
    chk({name, "_in_port"}, bus.in_port, exp_port);
    chk({name, "_interrupt"}, bus.interrupt, exp_int);
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    bus.port_id = 8'h03;
    bus.read_strobe = 0;
    bus.interrupt_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_port", bus.in_port, 8'h00);
    chk("reset_interrupt", bus.interrupt, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_break_flag", dut.break_flag, 0);
    reset = 0;
    settled = 1;
    half();
    send_frame(KEY_W, 0, 0, 1);
    peek("t1_make", 8'h03, 8'h1D, 1);
    ack();
    peek("t1_ack", 8'h03, 8'h1D, 0);
    send_frame(KEY_S, 0, 0, 0);
    peek("t2_make", 8'h03, 8'h1B, 1);
    ack();
    send_frame(BREAK_CODE, 0, 0, 0);
    send_frame(KEY_S, 0, 0, 0);
    peek("t2_release", 8'h03, 8'h1B, 0);
    chk("t2_break_flag", dut.break_flag, 0);
    send_frame(KEY_W, 1, 0, 0);
    peek("t3_parity", 8'h03, 8'h1B, 0);
    chk("t3_frame_errors", ferr_cnt, 1);
    settled = 0;
    send_bit(0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (TO + 50) @(negedge clk);
    m_ferr++;
    settled = 1;
    chk("t4_timeout_errors", ferr_cnt, 2);
    send_frame(KEY_S, 0, 0, 0);
    peek("t4_after", 8'h03, 8'h1B, 1);
    ack();
    send_frame(KEY_W, 0, 0, 0);
    send_frame(KEY_S, 0, 0, 0);
    peek("t5_overrun", 8'h03, 8'h1B, 1);
    chk("t5_overrun_set", overrun, 1);
    do_reset();
    send_frame(KEY_W, 0, 0, 0);
    send_frame(KEY_S, 0, 1, 0);
    peek("t5_ack_race", 8'h03, 8'h1B, 1);
    chk("t5_no_overrun", overrun, 0);
    ack();
    settled = 0;
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    do_reset();
    send_frame(EXT_CODE, 0, 0, 0);
    peek("t6_ext", 8'h03, 8'h00, 0);
    send_frame(KEY_W, 0, 0, 0);
    peek("t6_make", 8'h03, 8'h1D, 1);
    peek("t6_other_port", 8'h02, 8'h00, 1);
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: c = KEY_W;
        1: c = KEY_S;
        2: c = BREAK_CODE;
        3: c = EXT_CODE;
        default: c = 8'($urandom);
      endcase
      send_frame(c, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 0);
      if ($urandom_range(0, 2) == 0) ack();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
